// File: rtl/convertidor_bcd_bin.sv
// Sequential BCD-to-binary converter: three BCD digits in, 10-bit binary out.
// Uses reverse double-dabble (shift right, subtract 3), one shift per clock.
module convertidor_bcd_bin (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] centenasBCD,
    input  logic [3:0] decenasBCD,
    input  logic [3:0] unidadesBCD,
    output logic [9:0] numBinario,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] bcd_q, bcd_d;
    logic [9:0]  bin_q, bin_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  num_q, num_d;
    logic        err_q, err_d;

    logic [11:0] bcd_shifted;
    logic [11:0] bcd_adjusted;
    logic [9:0]  bin_shifted;
    logic        digit_invalid;

    // One right shift of {bcd, bin}: the BCD LSB moves into the binary MSB.
    assign bcd_shifted = {1'b0, bcd_q[11:1]};
    assign bin_shifted = {bcd_q[0], bin_q[9:1]};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_nibble_adj
            assign bcd_adjusted[gi*4 +: 4] = (bcd_shifted[gi*4 +: 4] >= 4'd8)
                                           ? bcd_shifted[gi*4 +: 4] - 4'd3
                                           : bcd_shifted[gi*4 +: 4];
        end
    endgenerate

    assign digit_invalid = (centenasBCD > 4'd9) || (decenasBCD > 4'd9) ||
                           (unidadesBCD > 4'd9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (digit_invalid) begin
                        // Rejected request keeps the previous result visible.
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        bcd_d   = {centenasBCD, decenasBCD, unidadesBCD};
                        bin_d   = '0;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                bcd_d = bcd_adjusted;
                bin_d = bin_shifted;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    num_d   = bin_shifted;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign numBinario = num_q;
    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign error      = err_q;

endmodule

// File: tb/tb_convertidor_bcd_bin.sv
// Self-checking bench for convertidor_bcd_bin: directed vectors plus an
// arithmetic reference model compared against the outputs every cycle.
module tb_convertidor_bcd_bin;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] centenasBCD;
    logic [3:0] decenasBCD;
    logic [3:0] unidadesBCD;
    logic [9:0] numBinario;
    logic       busy;
    logic       done;
    logic       error;

    int errors = 0;
    int checks = 0;

    convertidor_bcd_bin dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .centenasBCD (centenasBCD),
        .decenasBCD  (decenasBCD),
        .unidadesBCD (unidadesBCD),
        .numBinario  (numBinario),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a request is a value 100c+10d+u delivered after ten
    // clocks, followed by a single done cycle during which start is ignored.
    int   m_wait;
    int   m_pend;
    int   m_num;
    logic m_busy;
    logic m_done;
    logic m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wait <= 0;
            m_pend <= 0;
            m_num  <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_err  <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_num  <= m_pend;
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end
        end else if (start) begin
            if (centenasBCD > 9 || decenasBCD > 9 || unidadesBCD > 9) begin
                m_err  <= 1'b1;
                m_done <= 1'b1;
            end else begin
                m_err  <= 1'b0;
                m_pend <= 100 * int'(centenasBCD) + 10 * int'(decenasBCD) + int'(unidadesBCD);
                m_wait <= 10;
                m_busy <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("model_num",  int'(numBinario), m_num);
        chk("model_busy", int'(busy),       int'(m_busy));
        chk("model_done", int'(done),       int'(m_done));
        chk("model_err",  int'(error),      int'(m_err));
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Issues one start pulse and measures latency and busy cycles to done.
    task automatic req(input int c, input int d, input int u, input int exp_lat,
                       input int exp_num, input int exp_err, input int exp_busy);
        int lat;
        int busy_n;
        @(negedge clk);
        centenasBCD = 4'(c);
        decenasBCD  = 4'(d);
        unidadesBCD = 4'(u);
        start       = 1'b1;
        @(posedge clk);
        #2;
        start  = 1'b0;
        lat    = 0;
        busy_n = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #2;
            lat++;
            if (busy) busy_n++;
        end
        chk("latency",    lat,              exp_lat);
        chk("result",     int'(numBinario), exp_num);
        chk("error_flag", int'(error),      exp_err);
        chk("busy_count", busy_n,           exp_busy);
        @(posedge clk);
        #2;
        chk("done_width", int'(done), 0);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #2;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int seen;
        rst         = 1'b1;
        start       = 1'b0;
        centenasBCD = 4'd0;
        decenasBCD  = 4'd0;
        unidadesBCD = 4'd0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_num",  int'(numBinario), 0);
        chk("reset_busy", int'(busy),       0);
        chk("reset_done", int'(done),       0);
        chk("reset_err",  int'(error),      0);
        @(negedge clk);
        rst = 1'b0;

        req(2, 5, 5, 10, 255, 0, 10);
        req(9, 9, 9, 10, 999, 0, 10);
        req(0, 0, 0, 10, 0, 0, 10);
        req(9, 9, 9, 10, 999, 0, 10);
        req(1, 10, 3, 0, 999, 1, 0);
        req(1, 2, 3, 10, 123, 0, 10);
        req(15, 0, 0, 0, 123, 1, 0);
        req(0, 0, 12, 0, 123, 1, 0);
        req(5, 0, 7, 10, 507, 0, 10);

        // Extra start and digit changes during a conversion must be ignored.
        @(negedge clk);
        centenasBCD = 4'd4; decenasBCD = 4'd5; unidadesBCD = 4'd6; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        centenasBCD = 4'd0; decenasBCD = 4'd0; unidadesBCD = 4'd1; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        centenasBCD = 4'd7; decenasBCD = 4'd7; unidadesBCD = 4'd7;
        wait_done(lat);
        chk("ignore_lat",    lat,              5);
        chk("ignore_result", int'(numBinario), 456);
        repeat (2) @(posedge clk);

        // Reset in the middle of a conversion aborts it without a done pulse.
        @(negedge clk);
        centenasBCD = 4'd8; decenasBCD = 4'd0; unidadesBCD = 4'd0; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_num",  int'(numBinario), 0);
        chk("abort_busy", int'(busy),       0);
        chk("abort_done", int'(done),       0);
        chk("abort_err",  int'(error),      0);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #2;
            if (done) seen++;
        end
        chk("abort_no_done", seen, 0);
        req(8, 0, 0, 10, 800, 0, 10);

        // Start held high: back-to-back conversions re-sample the digits.
        @(negedge clk);
        centenasBCD = 4'd3; decenasBCD = 4'd2; unidadesBCD = 4'd1; start = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (done) seen++;
            centenasBCD = 4'((i * 7) % 10);
            decenasBCD  = 4'((i * 3) % 10);
            unidadesBCD = 4'(i % 10);
        end
        start = 1'b0;
        chk("held_start_done_count", seen, 3);
        repeat (14) @(posedge clk);

        for (int c = 0; c < 10; c++) begin
            for (int d = 0; d < 10; d++) begin
                for (int u = 0; u < 10; u++) begin
                    req(c, d, u, 10, 100 * c + 10 * d + u, 0, 10);
                end
            end
        end

        repeat (2) @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
